fp16_psum_accumulator: RTL and testbench

Sequential partial-sum accumulator for half-precision (IEEE-754 binary16) products, sitting directly downstream of the multiplier lane and wrapping the combinational 16-bit floating-point adder. It accepts one product per cycle over a valid/ready stream and skips zero operands, consistent with cnvlutin zero-skipping. It folds each product into a running sum and emits one result per group, delimited by `in_last`, together with sticky exception flags.

---
 rtl/fp16_acc_pkg.sv | 25 ++
 rtl/floating_point_16bit_adder.sv | 87 ++++++++
 rtl/fp16_psum_accumulator.sv | 116 +++++++++++
 tb/tb_fp16_psum_accumulator.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_acc_pkg.sv
// Shared constants, flag bundle, FSM states and zero test for the fp16 partial-sum accumulator.
// Holds no logic of its own, so it adds no latency and has no flow-control behaviour.
package fp16_acc_pkg;

    localparam logic [15:0] FP16_ZERO    = 16'h0000;
    localparam logic [4:0]  FP16_EXP_MAX = 5'd31;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_t;

    typedef struct packed {
        logic overflow;
        logic underflow;
        logic infinity;
        logic nan;
    } acc_flags_t;

    // +0 and -0 are both zero; the sign bit is ignored.
    function automatic logic fp16_is_zero(input logic [15:0] v);
        return v[14:0] == 15'd0;
    endfunction

endpackage

// File: rtl/floating_point_16bit_adder.sv
// Combinational binary16 adder, round-to-nearest-even, with subnormal support and exception flags.
// Zero latency and no handshake: the result settles within the same cycle.
module floating_point_16bit_adder (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum,
    output logic        overflow,
    output logic        underflow,
    output logic        infinity,
    output logic        nan
);

    logic        swap;
    logic [15:0] x, y;
    logic [4:0]  ex, ey;
    logic [10:0] mx, my;
    logic [41:0] xa, ya, s, n;
    logic [5:0]  p, lz, sh, ex6;
    logic [6:0]  er, er_f;
    logic [10:0] m11, mant;
    logic        rnd;
    logic [11:0] mr;
    logic        x_nan, y_nan, x_inf, y_inf;

    // x is always the operand of larger magnitude, so the aligned difference never goes negative.
    assign swap = b[14:0] > a[14:0];
    assign x    = swap ? b : a;
    assign y    = swap ? a : b;
    assign ex   = (x[14:10] == 5'd0) ? 5'd1 : x[14:10];
    assign ey   = (y[14:10] == 5'd0) ? 5'd1 : y[14:10];
    assign mx   = {x[14:10] != 5'd0, x[9:0]};
    assign my   = {y[14:10] != 5'd0, y[9:0]};
    assign ex6  = {1'b0, ex};

    // 30 spare low bits absorb the largest possible alignment shift, so s is exact.
    assign xa = {1'b0, mx, 30'd0};
    assign ya = {1'b0, my, 30'd0} >> (ex - ey);
    assign s  = (x[15] ^ y[15]) ? xa - ya : xa + ya;

    always_comb begin
        p = 6'd0;
        for (int i = 0; i < 42; i++) begin
            if (s[i]) p = 6'(i);
        end
    end

    // Normalisation is capped at the minimum exponent; anything below that falls out as a subnormal.
    assign lz   = 6'd41 - p;
    assign sh   = (lz > ex6) ? ex6 : lz;
    assign n    = s << sh;
    assign er   = {2'b00, ex} + 7'd1 - {1'b0, sh};
    assign m11  = n[41:31];
    assign rnd  = n[30] & ((|n[29:0]) | m11[0]);
    assign mr   = {1'b0, m11} + {11'd0, rnd};
    assign mant = mr[11] ? mr[11:1] : mr[10:0];
    assign er_f = mr[11] ? er + 7'd1 : er;

    assign x_nan = (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
    assign y_nan = (y[14:10] == 5'h1F) && (y[9:0] != 10'd0);
    assign x_inf = (x[14:10] == 5'h1F) && (x[9:0] == 10'd0);
    assign y_inf = (y[14:10] == 5'h1F) && (y[9:0] == 10'd0);

    always_comb begin
        sum       = 16'h0000;
        overflow  = 1'b0;
        underflow = 1'b0;
        infinity  = 1'b0;
        nan       = 1'b0;
        if (x_nan || y_nan || (x_inf && y_inf && (x[15] != y[15]))) begin
            sum = 16'h7E00;
            nan = 1'b1;
        end else if (x_inf) begin
            sum      = x;
            infinity = 1'b1;
        end else if (s == 42'd0) begin
            sum = {x[15] & y[15], 15'd0};
        end else if (er_f >= 7'd31) begin
            sum      = {x[15], 5'h1F, 10'd0};
            overflow = 1'b1;
            infinity = 1'b1;
        end else begin
            sum       = {x[15], mant[10] ? er_f[4:0] : 5'd0, mant[9:0]};
            underflow = ~mant[10];
        end
    end

endmodule

// File: rtl/fp16_psum_accumulator.sv
// Folds a stream of fp16 products into one sum per in_last-delimited group, skipping zero operands.
// One cycle per beat; in_ready drops while a result is held until out_ready takes it.
module fp16_psum_accumulator
    import fp16_acc_pkg::*;
#(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [15:0]        in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [15:0]        out_data,
    output logic               out_overflow,
    output logic               out_underflow,
    output logic               out_infinity,
    output logic               out_nan,
    output logic [COUNT_W-1:0] out_count
);

    acc_state_t         state, state_nxt;
    logic [15:0]        acc, acc_nxt, add_sum;
    acc_flags_t         flags, flags_nxt, add_flags;
    logic [COUNT_W-1:0] count, count_nxt;
    logic               accept;
    logic               add_ovf, add_unf, add_inf, add_nan;

    floating_point_16bit_adder u_adder (
        .a         (acc),
        .b         (in_data),
        .sum       (add_sum),
        .overflow  (add_ovf),
        .underflow (add_unf),
        .infinity  (add_inf),
        .nan       (add_nan)
    );

    assign add_flags = '{overflow: add_ovf, underflow: add_unf, infinity: add_inf, nan: add_nan};
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) state <= ACCUM;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && in_last) state_nxt = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = ACCUM;
            end
            default: state_nxt = ACCUM;
        endcase
    end

    // An empty accumulator takes the product verbatim so the adder never sees a zero operand.
    always_comb begin
        acc_nxt   = acc;
        flags_nxt = flags;
        count_nxt = count;
        if (!fp16_is_zero(in_data)) begin
            if (fp16_is_zero(acc)) begin
                acc_nxt            = in_data;
                flags_nxt.infinity = flags.infinity |
                                     ((in_data[14:10] == FP16_EXP_MAX) && (in_data[9:0] == 10'd0));
                flags_nxt.nan      = flags.nan |
                                     ((in_data[14:10] == FP16_EXP_MAX) && (in_data[9:0] != 10'd0));
            end else begin
                acc_nxt   = add_sum;
                flags_nxt = flags | add_flags;
            end
            count_nxt = (&count) ? count : count + {{(COUNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc           <= FP16_ZERO;
            flags         <= '0;
            count         <= '0;
            out_data      <= FP16_ZERO;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            out_infinity  <= 1'b0;
            out_nan       <= 1'b0;
            out_count     <= '0;
        end else if (accept) begin
            if (in_last) begin
                out_data      <= acc_nxt;
                out_overflow  <= flags_nxt.overflow;
                out_underflow <= flags_nxt.underflow;
                out_infinity  <= flags_nxt.infinity;
                out_nan       <= flags_nxt.nan;
                out_count     <= count_nxt;
                acc           <= FP16_ZERO;
                flags         <= '0;
                count         <= '0;
            end else begin
                acc   <= acc_nxt;
                flags <= flags_nxt;
                count <= count_nxt;
            end
        end
    end

endmodule

// File: tb/tb_fp16_psum_accumulator.sv
// Randomised and directed checks of the accumulator against a real-arithmetic fp16 reference model.
module tb_fp16_psum_accumulator;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_last, out_ready;
    logic [15:0] in_data;
    logic        in_ready, out_valid, ovf, unf, inf, nan;
    logic [15:0] out_data;
    logic [7:0]  out_count;
    logic        in_ready2, out_valid2, ovf2, unf2, inf2, nan2;
    logic [15:0] out_data2;
    logic [1:0]  out_count2;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] gq[$];
    logic [15:0] obs_data;
    logic [3:0]  obs_flags;
    logic [7:0]  obs_cnt;
    logic [1:0]  obs_cnt2;

    always #5 clk = ~clk;

    fp16_psum_accumulator dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_overflow(ovf), .out_underflow(unf), .out_infinity(inf),
        .out_nan(nan), .out_count(out_count)
    );

    fp16_psum_accumulator #(.COUNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid2), .out_ready(out_ready),
        .out_data(out_data2), .out_overflow(ovf2), .out_underflow(unf2), .out_infinity(inf2),
        .out_nan(nan2), .out_count(out_count2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic real pow2(input int e);
        real r = 1.0;
        if (e >= 0) repeat (e) r = r * 2.0;
        else        repeat (-e) r = r / 2.0;
        return r;
    endfunction

    function automatic logic is_nan(input logic [15:0] h);
        return (h[14:10] == 5'd31) && (h[9:0] != 10'd0);
    endfunction

    function automatic logic is_inf(input logic [15:0] h);
        return (h[14:10] == 5'd31) && (h[9:0] == 10'd0);
    endfunction

    function automatic real to_real(input logic [15:0] h);
        int  e = int'(h[14:10]);
        int  f = int'(h[9:0]);
        real m = (e == 0) ? real'(f) * pow2(-24) : real'(f + 1024) * pow2(e - 25);
        return h[15] ? -m : m;
    endfunction

    // Rounds an exact nonzero real to the nearest binary16, ties to even.
    function automatic logic [15:0] from_real(input real x);
        logic sg = (x < 0.0);
        real  a  = sg ? -x : x;
        int   e, qi, ee, fr;
        real  q, r;
        if (a >= 65520.0) return {sg, 15'h7C00};
        if (a < pow2(-14)) begin
            qi = $rtoi(a * pow2(24));
            return {sg, 5'd0, qi[9:0]};
        end
        e = -14;
        while (a >= pow2(e + 1)) e++;
        q  = a * pow2(10 - e);
        qi = $rtoi(q);
        r  = q - real'(qi);
        if (r > 0.5 || (r == 0.5 && (qi % 2) == 1)) qi++;
        if (qi == 2048) begin
            qi = 1024;
            e++;
        end
        ee = e + 15;
        fr = qi - 1024;
        return {sg, ee[4:0], fr[9:0]};
    endfunction

    // Returns {overflow, underflow, infinity, nan, sum}.
    function automatic logic [19:0] ref_add(input logic [15:0] a, input logic [15:0] b);
        real         r;
        logic [15:0] res;
        if (is_nan(a) || is_nan(b) || (is_inf(a) && is_inf(b) && a[15] != b[15]))
            return {4'b0001, 16'h7E00};
        if (is_inf(a)) return {4'b0010, a};
        if (is_inf(b)) return {4'b0010, b};
        r = to_real(a) + to_real(b);
        if (r == 0.0) return {4'b0000, a[15] & b[15], 15'd0};
        res = from_real(r);
        return {is_inf(res), res[14:10] == 5'd0, is_inf(res), 1'b0, res};
    endfunction

    task automatic model_group(output logic [15:0] d, output logic [3:0] fl, output int cnt);
        logic [19:0] r;
        d = 16'h0000; fl = 4'b0000; cnt = 0;
        foreach (gq[i]) begin
            if (gq[i][14:0] != 15'd0) begin
                if (d[14:0] == 15'd0) begin
                    d  = gq[i];
                    fl = fl | {2'b00, is_inf(gq[i]), is_nan(gq[i])};
                end else begin
                    r  = ref_add(d, gq[i]);
                    d  = r[15:0];
                    fl = fl | r[19:16];
                end
                cnt++;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    function automatic logic [15:0] rand_fp16();
        logic [15:0] v = 16'($urandom);
        case ($urandom_range(0, 15))
            0, 1, 2: v[14:0] = 15'd0;
            3:       v[14:10] = 5'd0;
            4:       v[14:10] = 5'($urandom_range(1, 30));
            5:       v[14:0] = ($urandom_range(0, 1) == 0) ? 15'h7C00 : 15'h7E00;
            default: v[14:10] = 5'($urandom_range(12, 18));
        endcase
        return v;
    endfunction

    task automatic send_beat(input logic [15:0] d, input logic last);
        int w = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && w < 50) begin
            step();
            w++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'($urandom);
        in_data  = 16'($urandom);
    endtask

    task automatic run_group(input string name, input int gap_max, input int hold_max);
        logic [15:0] ed;
        logic [3:0]  ef;
        int          ec;
        model_group(ed, ef, ec);
        for (int i = 0; i < gq.size(); i++) begin
            repeat ($urandom_range(0, gap_max)) step();
            send_beat(gq[i], i == gq.size() - 1);
        end
        obs_data  = out_data;
        obs_flags = {ovf, unf, inf, nan};
        obs_cnt   = out_count;
        obs_cnt2  = out_count2;
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_valid2"}, 32'(out_valid2), 32'd1);
        chk({name, "_data"}, 32'(out_data), 32'(ed));
        chk({name, "_data2"}, 32'(out_data2), 32'(ed));
        chk({name, "_flags"}, 32'(obs_flags), 32'(ef));
        chk({name, "_flags2"}, 32'({ovf2, unf2, inf2, nan2}), 32'(ef));
        chk({name, "_count"}, 32'(out_count), (ec > 255) ? 32'd255 : 32'(ec));
        chk({name, "_count2"}, 32'(out_count2), (ec > 3) ? 32'd3 : 32'(ec));
        repeat ($urandom_range(0, hold_max)) begin
            step();
            chk({name, "_hold_rdy"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] held;
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 16'h0000; out_ready = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_in_ready2", 32'(in_ready2), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_count", 32'(out_count), 32'd0);

        gq = {}; gq.push_back(16'h3C00); gq.push_back(16'h4000); gq.push_back(16'h3800);
        run_group("basic", 0, 0);
        chk("basic_lit", 32'(obs_data), 32'h4300);
        chk("basic_cnt_lit", 32'(obs_cnt), 32'd3);

        gq = {}; gq.push_back(16'h0000); gq.push_back(16'h8000); gq.push_back(16'h3C00); gq.push_back(16'h0000);
        run_group("zskip", 1, 1);
        chk("zskip_lit", 32'(obs_data), 32'h3C00);
        chk("zskip_cnt_lit", 32'(obs_cnt), 32'd1);

        gq = {}; gq.push_back(16'h8000); gq.push_back(16'h0000);
        run_group("allzero", 0, 0);
        chk("allzero_lit", 32'(obs_data), 32'h0000);

        gq = {}; gq.push_back(16'h7BFF); gq.push_back(16'h7BFF);
        run_group("ovf", 0, 0);
        chk("ovf_flag_lit", 32'(obs_flags[3]), 32'd1);

        gq = {}; gq.push_back(16'h7C00);
        run_group("inf", 0, 0);
        chk("inf_lit", 32'({obs_data, obs_flags}), 32'h7C002);

        gq = {}; gq.push_back(16'h7E00);
        run_group("nan", 0, 0);
        chk("nan_flags_lit", 32'(obs_flags), 32'b0001);

        // Backpressure: result held five cycles while the next beat waits.
        in_valid = 1'b1; in_data = 16'h3C00; in_last = 1'b0; step();
        in_data = 16'h4000; in_last = 1'b1; step();
        chk("bp_valid", 32'(out_valid), 32'd1);
        held = out_data;
        chk("bp_data", 32'(held), 32'h4200);
        in_data = 16'h3800; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_stable", 32'(out_data), 32'(held));
        end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        chk("bp_release", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp_next_valid", 32'(out_valid), 32'd1);
        chk("bp_next_data", 32'(out_data), 32'h3800);
        chk("bp_next_count", 32'(out_count), 32'd1);
        out_ready = 1'b1; step(); out_ready = 1'b0;

        // Reset in the middle of a group discards the partial sum.
        send_beat(16'h3C00, 1'b0);
        send_beat(16'h4000, 1'b0);
        reset = 1'b1; step(); reset = 1'b0;
        chk("mrst_in_ready", 32'(in_ready), 32'd1);
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        gq = {}; gq.push_back(16'h3800);
        run_group("mrst", 0, 0);
        chk("mrst_lit", 32'(obs_data), 32'h3800);
        chk("mrst_cnt_lit", 32'(obs_cnt), 32'd1);

        gq = {};
        repeat (5) gq.push_back(16'h3C00);
        run_group("sat", 0, 0);
        chk("sat_lit", 32'(obs_data), 32'h4500);
        chk("sat_cnt2_lit", 32'(obs_cnt2), 32'd3);
        chk("sat_cnt8_lit", 32'(obs_cnt), 32'd5);

        for (int g = 0; g < 80; g++) begin
            gq = {};
            repeat ($urandom_range(1, 9)) gq.push_back(rand_fp16());
            run_group("rand", 2, 3);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
